// File: rtl/rob_retire_unit_pkg.sv
// rtl/rob_retire_unit_pkg.sv - shared types and widths for the ROB retire stage
package rob_retire_unit_pkg;

  localparam int TAG_WIDTH      = 6;
  localparam int NUM_TAGS       = 2 ** TAG_WIDTH;
  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } retire_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mispredict;
    logic [DATA_WIDTH-1:0]     target;
  } cdb_entry_t;

endpackage

// File: rtl/rob_retire_unit_completion_table.sv
// rtl/rob_retire_unit_completion_table.sv - tag-indexed completion results with done bits
module rob_retire_unit_completion_table #(
  parameter int TAG_WIDTH = rob_retire_unit_pkg::TAG_WIDTH,
  parameter int NUM_TAGS  = rob_retire_unit_pkg::NUM_TAGS
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             wr_en,
  input  logic [TAG_WIDTH-1:0]             wr_tag,
  input  rob_retire_unit_pkg::cdb_entry_t  wr_entry,
  input  logic                             clr_en,
  input  logic [TAG_WIDTH-1:0]             clr_tag,
  input  logic                             clr_all,
  input  logic [TAG_WIDTH-1:0]             head_tag,
  output logic                             head_done,
  output rob_retire_unit_pkg::cdb_entry_t  head_entry
);

  import rob_retire_unit_pkg::*;

  logic [NUM_TAGS-1:0] done_q;
  cdb_entry_t          entries [NUM_TAGS];

  // Write is applied after the clear so a same-tag completion wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= '0;
    end else if (clr_all) begin
      done_q <= '0;
    end else begin
      if (clr_en) done_q[clr_tag] <= 1'b0;
      if (wr_en)  done_q[wr_tag]  <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) entries[wr_tag] <= wr_entry;
  end

  assign head_done  = done_q[head_tag];
  assign head_entry = entries[head_tag];

endmodule

// File: rtl/rob_retire_unit.sv
// rtl/rob_retire_unit.sv - in-order retire from ROB head with mispredict flush/redirect
module rob_retire_unit #(
  parameter int TAG_WIDTH      = rob_retire_unit_pkg::TAG_WIDTH,
  parameter int NUM_TAGS       = rob_retire_unit_pkg::NUM_TAGS,
  parameter int DATA_WIDTH     = rob_retire_unit_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = rob_retire_unit_pkg::REG_ADDR_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [TAG_WIDTH-1:0]      i_rob_head_tag,
  input  logic                      i_rob_empty,
  input  logic                      i_cdb_valid,
  input  logic [TAG_WIDTH-1:0]      i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]     i_cdb_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_cdb_rd,
  input  logic                      i_cdb_reg_write,
  input  logic                      i_cdb_mispredict,
  input  logic [DATA_WIDTH-1:0]     i_cdb_target,
  output logic                      o_retire_completed,
  output logic                      o_rf_we,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_waddr,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  output logic [TAG_WIDTH-1:0]      o_retire_tag,
  output logic                      o_flush,
  output logic                      o_redirect_valid,
  output logic [DATA_WIDTH-1:0]     o_redirect_pc
);

  import rob_retire_unit_pkg::*;

  retire_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] target_q;
  logic                  retire;
  logic                  flush;
  logic                  head_done;
  cdb_entry_t            head_entry;
  cdb_entry_t            cdb_entry;

  assign cdb_entry = '{data:       i_cdb_data,
                       rd:         i_cdb_rd,
                       reg_write:  i_cdb_reg_write,
                       mispredict: i_cdb_mispredict,
                       target:     i_cdb_target};

  rob_retire_unit_completion_table #(
    .TAG_WIDTH (TAG_WIDTH),
    .NUM_TAGS  (NUM_TAGS)
  ) u_table (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .wr_en      (i_cdb_valid && state_q == RUN),
    .wr_tag     (i_cdb_tag),
    .wr_entry   (cdb_entry),
    .clr_en     (retire),
    .clr_tag    (i_rob_head_tag),
    .clr_all    (flush),
    .head_tag   (i_rob_head_tag),
    .head_done  (head_done),
    .head_entry (head_entry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RUN;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire && head_entry.mispredict) target_q <= head_entry.target;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        retire = !i_rob_empty && head_done;
        if (retire && head_entry.mispredict) state_d = FLUSH;
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign o_retire_completed = retire;
  assign o_retire_tag       = i_rob_head_tag;
  // x0 is hardwired zero: the instruction retires but the write is dropped.
  assign o_rf_we            = retire && head_entry.reg_write && (head_entry.rd != '0);
  assign o_rf_waddr         = o_rf_we ? head_entry.rd   : '0;
  assign o_rf_wdata         = o_rf_we ? head_entry.data : '0;
  assign o_flush            = flush;
  assign o_redirect_valid   = flush;
  assign o_redirect_pc      = flush ? target_q : '0;

endmodule

// File: tb/tb_rob_retire_unit.sv
// tb/tb_rob_retire_unit.sv - directed and randomized checks of rob_retire_unit against a behavioural model
module tb_rob_retire_unit;

  localparam int TW = 6;
  localparam int NT = 64;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [TW-1:0] i_rob_head_tag = '0;
  logic          i_rob_empty = 1'b1;
  logic          i_cdb_valid = 1'b0;
  logic [TW-1:0] i_cdb_tag = '0;
  logic [DW-1:0] i_cdb_data = '0;
  logic [RW-1:0] i_cdb_rd = '0;
  logic          i_cdb_reg_write = 1'b0;
  logic          i_cdb_mispredict = 1'b0;
  logic [DW-1:0] i_cdb_target = '0;
  logic          o_retire_completed, o_rf_we, o_flush, o_redirect_valid;
  logic [RW-1:0] o_rf_waddr;
  logic [DW-1:0] o_rf_wdata, o_redirect_pc;
  logic [TW-1:0] o_retire_tag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-tag completion record plus a pending-flush flag.
  bit          m_done [NT];
  logic [31:0] m_data [NT];
  int          m_rd   [NT];
  bit          m_rw   [NT];
  bit          m_mis  [NT];
  logic [31:0] m_tgt  [NT];
  bit          m_flush_next;
  logic [31:0] m_flush_pc;

  always #5 i_clk = ~i_clk;

  rob_retire_unit dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rob_head_tag     (i_rob_head_tag),
    .i_rob_empty        (i_rob_empty),
    .i_cdb_valid        (i_cdb_valid),
    .i_cdb_tag          (i_cdb_tag),
    .i_cdb_data         (i_cdb_data),
    .i_cdb_rd           (i_cdb_rd),
    .i_cdb_reg_write    (i_cdb_reg_write),
    .i_cdb_mispredict   (i_cdb_mispredict),
    .i_cdb_target       (i_cdb_target),
    .o_retire_completed (o_retire_completed),
    .o_rf_we            (o_rf_we),
    .o_rf_waddr         (o_rf_waddr),
    .o_rf_wdata         (o_rf_wdata),
    .o_retire_tag       (o_retire_tag),
    .o_flush            (o_flush),
    .o_redirect_valid   (o_redirect_valid),
    .o_redirect_pc      (o_redirect_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_done[i] = 1'b0;
    m_flush_next = 1'b0;
    m_flush_pc   = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_retire"}, 32'(o_retire_completed), 0);
    check({tag, "_rf_we"},  32'(o_rf_we), 0);
    check({tag, "_waddr"},  32'(o_rf_waddr), 0);
    check({tag, "_wdata"},  o_rf_wdata, 0);
    check({tag, "_flush"},  32'(o_flush), 0);
    check({tag, "_redir"},  32'(o_redirect_valid), 0);
    check({tag, "_pc"},     o_redirect_pc, 0);
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit e, input int h, input bit cv, input int ct, input logic [31:0] cd,
                      input int crd, input bit crw, input bit cm, input logic [31:0] ctg);
    bit          exp_ret, exp_we;
    int          exp_waddr;
    logic [31:0] exp_wdata;
    @(negedge i_clk);
    i_rob_empty = e;       i_rob_head_tag = TW'(h);
    i_cdb_valid = cv;      i_cdb_tag = TW'(ct);   i_cdb_data = cd;
    i_cdb_rd = RW'(crd);   i_cdb_reg_write = crw; i_cdb_mispredict = cm; i_cdb_target = ctg;
    #1;
    exp_ret   = !m_flush_next && !e && m_done[h];
    exp_we    = exp_ret && m_rw[h] && m_rd[h] != 0;
    exp_waddr = exp_we ? m_rd[h] : 0;
    exp_wdata = exp_we ? m_data[h] : 32'h0;
    check("retire", 32'(o_retire_completed), 32'(exp_ret));
    check("tag",    32'(o_retire_tag), 32'(h));
    check("rf_we",  32'(o_rf_we), 32'(exp_we));
    check("waddr",  32'(o_rf_waddr), 32'(exp_waddr));
    check("wdata",  o_rf_wdata, exp_wdata);
    check("flush",  32'(o_flush), 32'(m_flush_next));
    check("redir",  32'(o_redirect_valid), 32'(m_flush_next));
    check("pc",     o_redirect_pc, m_flush_next ? m_flush_pc : 32'h0);
    @(posedge i_clk);
    if (m_flush_next) begin
      for (int i = 0; i < NT; i++) m_done[i] = 1'b0;
      m_flush_next = 1'b0;
    end else begin
      if (exp_ret) begin
        m_done[h] = 1'b0;
        if (m_mis[h]) begin
          m_flush_next = 1'b1;
          m_flush_pc   = m_tgt[h];
        end
      end
      if (cv) begin
        m_done[ct] = 1'b1; m_data[ct] = cd; m_rd[ct] = crd;
        m_rw[ct] = crw;    m_mis[ct] = cm;  m_tgt[ct] = ctg;
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic: table empty at head 5, then completion and 1-cycle-later retire.
    step(0, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 5, 1, 5, 32'hDEAD, 3, 1, 0, 0);
    step(0, 5, 0, 0, 0, 0, 0, 0, 0);
    // Out-of-order completion, in-order retire.
    step(1, 0, 1, 8, 32'h8888, 8, 1, 0, 0);
    step(1, 0, 1, 7, 32'h7777, 7, 1, 0, 0);
    step(0, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 8, 0, 0, 0, 0, 0, 0, 0);
    // Write to x0 retires without a register write.
    step(1, 0, 1, 2, 32'h2222, 0, 1, 0, 0);
    step(0, 2, 0, 0, 0, 0, 0, 0, 0);
    // Mispredict flushes younger completions.
    step(1, 0, 1, 9, 32'h9999, 9, 1, 0, 0);
    step(1, 0, 1, 10, 32'hAAAA, 10, 1, 0, 0);
    step(1, 0, 1, 4, 32'h4444, 4, 1, 1, 32'h100);
    step(0, 4, 1, 11, 32'hBBBB, 11, 1, 0, 0);
    step(0, 9, 1, 12, 32'hCCCC, 12, 1, 0, 0);
    step(0, 9, 0, 0, 0, 0, 0, 0, 0);
    step(0, 10, 0, 0, 0, 0, 0, 0, 0);
    step(0, 11, 0, 0, 0, 0, 0, 0, 0);
    // Retire of tag 3 coincident with completion of tag 6.
    step(1, 0, 1, 3, 32'h3333, 3, 1, 0, 0);
    step(0, 3, 1, 6, 32'h6666, 6, 1, 0, 0);
    step(0, 6, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted during the flush cycle aborts it immediately.
    step(1, 0, 1, 20, 32'h2020, 1, 1, 0, 0);
    step(1, 0, 1, 21, 32'h2121, 2, 1, 1, 32'h400);
    step(0, 21, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    i_rob_empty = 1'b1; i_rob_head_tag = '0; i_cdb_valid = 1'b0;
    check("pre_rst_flush", 32'(o_flush), 1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("rst_flush");
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(0, 20, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic on a small tag window to keep retires frequent.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- In-order commit stage directly downstream of the ROB tag FIFO.
- Records completion results broadcast on the CDB, indexed by instruction tag.
- Each cycle, checks the ROB head tag. If that instruction is complete, it retires it: register-file write, tag release, head advance.
- A retired branch with a misprediction triggers a one-cycle pipeline flush and a fetch redirect.

Parameters:
- TAG_WIDTH, 6, instruction tag width; must match the ROB entry width.
- NUM_TAGS, 64, completion-table entries (2**TAG_WIDTH).
- DATA_WIDTH, 32, result/PC width.
- REG_ADDR_WIDTH, 5, architectural register index width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rob_head_tag  in  TAG_WIDTH  tag at ROB head (ROB data_out)
- i_rob_empty  in  1  ROB empty flag
- i_cdb_valid  in  1  CDB broadcast valid
- i_cdb_tag  in  TAG_WIDTH  tag of completing instruction
- i_cdb_data  in  DATA_WIDTH  result value
- i_cdb_rd  in  REG_ADDR_WIDTH  destination register
- i_cdb_reg_write  in  1  instruction writes rd
- i_cdb_mispredict  in  1  branch resolved mispredicted
- i_cdb_target  in  DATA_WIDTH  correct branch target
- o_retire_completed  out  1  pulse that advances ROB head
- o_rf_we  out  1  register-file write enable
- o_rf_waddr  out  REG_ADDR_WIDTH  write address
- o_rf_wdata  out  DATA_WIDTH  write data
- o_retire_tag  out  TAG_WIDTH  retired tag (tag release / RST clear)
- o_flush  out  1  pipeline flush, one cycle
- o_redirect_valid  out  1  fetch redirect, coincident with o_flush
- o_redirect_pc  out  DATA_WIDTH  redirect target

Behaviour:
- Completion table: NUM_TAGS entries, each holding {done, data, rd, reg_write, mispredict, target}.
  - done bits are reset by i_rst_n. Payload fields are not reset.
- CDB capture, state RUN:
  - When i_cdb_valid is high, the entry at i_cdb_tag is written at posedge with done=1.
  - A later write to the same tag overwrites the entry.
- State machine (RUN, FLUSH):
  - Reset state is RUN.
  - RUN -> FLUSH when a retire occurs and the head entry's mispredict=1.
  - FLUSH -> RUN unconditionally after one cycle.
- Retire condition, combinational: retire = (state==RUN) & !i_rob_empty & done[i_rob_head_tag].
  - o_retire_completed = retire.
  - o_retire_tag = i_rob_head_tag.
  - o_rf_we = retire & reg_write & (rd != 0). Writes to x0 are suppressed, but the instruction still retires.
  - o_rf_waddr and o_rf_wdata come from the head entry. They are 0 whenever o_rf_we is 0.
- On retire, done[i_rob_head_tag] is cleared at posedge. Throughput is at most one retire per cycle.
- CDB write and clear in the same cycle:
  - Same tag: the CDB write wins (done=1). A tag is never re-completed while still at head; the table records the write regardless.
  - Different tags: both take effect.
- No CDB-to-retire bypass. A completion arriving at posedge N is retirable from cycle N onward (1-cycle latency from the CDB cycle).
- Mispredict retire in cycle N:
  - The branch retires normally in cycle N, including its rf write.
  - A target register is loaded at posedge N.
  - In cycle N+1 (FLUSH): o_flush=1, o_redirect_valid=1, o_redirect_pc=target.
  - FLUSH state also blocks retire and ignores the CDB.
  - At the posedge ending FLUSH, all done bits clear, so younger results are discarded.
- CDB inputs arriving in the mispredict-retire cycle are captured but cleared by the flush.
- Reset values, during and immediately after reset:
  - all outputs 0, state RUN, all done=0.
  - Reset mid-FLUSH aborts the flush.
- i_rob_empty=1: no retire, regardless of the table contents.

Decomposition:
- Shared package (utils.sv):
  - retire_state_t enum {RUN, FLUSH}
  - cdb_entry_t struct {data, rd, reg_write, mispredict, target}
  - TAG_WIDTH constant shared with the ROB
- One natural sub-module: completion_table, a NUM_TAGS-deep register array with write port (CDB), clear port (retire), global clear (flush), and an asynchronous read at head_tag.
- The FSM and output logic stay in the top level.

Test Plan:
- Reset, then ROB non-empty with head=5 and table empty -> o_retire_completed=0, all outputs 0. Then CDB tag=5, rd=3, data=0xDEAD, reg_write=1 -> next cycle o_retire_completed=1, o_rf_we=1, waddr=3, wdata=0xDEAD, o_retire_tag=5.
- Out-of-order completion: CDB tag 8, then tag 7. ROB head 7, then 8 -> tag 7 retires first, then tag 8 in the following cycle. Back-to-back retires, one per cycle.
- rd=0 with reg_write=1, tag=2 at head -> retire=1, o_rf_we=0, waddr=0, wdata=0.
- Mispredict: tag 4 completes with mispredict=1, target=0x100; younger tags 9 and 10 are already done -> cycle N retires tag 4; cycle N+1 o_flush=1, redirect_pc=0x100, no retire; afterwards done[9]=done[10]=0, with no retire of tag 9 even though it is at head.
- Simultaneous: head tag 3 retiring in the same cycle as CDB tag 6 -> tag 3 cleared, tag 6 done, tag 6 retires when it reaches head.
- Assert i_rst_n low during the FLUSH cycle -> o_flush=0 immediately (async), state RUN, all done bits 0.
